// File: rtl/uart_rx_deframer.sv
// UART receive deframer: synchronizes pc_data, recovers 8N1 frames with a 3-tap majority vote, and
// presents each byte on rx_valid/rx_ready. Optional even parity checking is enabled by RX_PARITY_EN.
`timescale 1ns/1ps

module uart_rx_deframer #(
   parameter int unsigned CLKS_PER_BIT = 650,
   parameter int unsigned SYNC_STAGES  = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pc_data,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       parity_err,
   output logic       rx_busy
);

   localparam int unsigned   CW       = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
`ifdef RX_PARITY_EN
      , S_PARITY
`endif
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [1:0]             hist_q, hist_d;
   logic [CW-1:0]          clk_cnt_q, clk_cnt_d;
   logic [2:0]             bit_cnt_q, bit_cnt_d;
   logic [7:0]             shift_q, shift_d;
   logic [7:0]             rx_data_q, rx_data_d;
   logic                   rx_valid_q, rx_valid_d;
   logic                   frame_err_q, frame_err_d;
   logic                   overrun_q, overrun_d;
   logic                   rx_busy_q, rx_busy_d;
`ifdef RX_PARITY_EN
   logic                   par_bad_q, par_bad_d;
   logic                   parity_err_q, parity_err_d;
`endif

   logic rxs;
   logic vote;
   logic bit_end;
   logic stop_good;

   assign rxs     = sync_q[SYNC_STAGES-1];
   // Majority of the current and two previous synchronized samples around the bit centre
   assign vote    = (rxs & hist_q[0]) | (rxs & hist_q[1]) | (hist_q[0] & hist_q[1]);
   assign bit_end = (clk_cnt_q == BIT_END);

`ifdef RX_PARITY_EN
   assign stop_good = vote & ~par_bad_q;
`else
   assign stop_good = vote;
`endif

   always_comb begin
      state_d     = state_q;
      sync_d      = {sync_q[SYNC_STAGES-2:0], pc_data};
      hist_d      = {hist_q[0], rxs};
      clk_cnt_d   = clk_cnt_q + CW'(1);
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = rx_valid_q & ~rx_ready;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
`ifdef RX_PARITY_EN
      par_bad_d    = par_bad_q;
      parity_err_d = 1'b0;
`endif

      case (state_q)
         S_IDLE: begin
            clk_cnt_d = '0;
            bit_cnt_d = '0;
            if (!rxs) state_d = S_START;
         end
         S_START: begin
            if (clk_cnt_q == HALF_END) begin
               clk_cnt_d = '0;
               bit_cnt_d = '0;
               state_d   = vote ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               clk_cnt_d = '0;
               shift_d   = {vote, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
`ifdef RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end
`ifdef RX_PARITY_EN
         S_PARITY: begin
            if (bit_end) begin
               clk_cnt_d = '0;
               par_bad_d = (vote != ^shift_q);
               state_d   = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (bit_end) begin
               // Leave at stop-bit centre so a following start edge is not missed
               clk_cnt_d = '0;
               state_d   = S_IDLE;
`ifdef RX_PARITY_EN
               parity_err_d = par_bad_q;
               frame_err_d  = ~par_bad_q & ~vote;
`else
               frame_err_d  = ~vote;
`endif
               if (stop_good) begin
                  if (rx_valid_q && !rx_ready) begin
                     overrun_d = 1'b1;
                  end else begin
                     rx_data_d  = shift_q;
                     rx_valid_d = 1'b1;
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      rx_busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         sync_q      <= '1;
         hist_q      <= '1;
         clk_cnt_q   <= '0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         rx_data_q   <= 8'h00;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         rx_busy_q   <= 1'b0;
`ifdef RX_PARITY_EN
         par_bad_q    <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         sync_q      <= sync_d;
         hist_q      <= hist_d;
         clk_cnt_q   <= clk_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
         rx_busy_q   <= rx_busy_d;
`ifdef RX_PARITY_EN
         par_bad_q    <= par_bad_d;
         parity_err_q <= parity_err_d;
`endif
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
   assign rx_busy   = rx_busy_q;
`ifdef RX_PARITY_EN
   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer with a shortened bit period (64 clocks per bit).
`timescale 1ns/1ps

module tb_uart_rx_deframer;

   localparam int unsigned CPB    = 64;
   localparam int          CLK_NS = 10;
   localparam int          BIT_NS = CPB * CLK_NS;

   logic       clk = 1'b0;
   logic       reset;
   logic       pc_data;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       frame_err;
   logic       overrun;
   logic       parity_err;
   logic       rx_busy;

   int n_checks = 0;
   int n_fail   = 0;
   int n_ferr   = 0;
   int n_ovr    = 0;
   int n_perr   = 0;
   bit busy_seen = 1'b0;
   logic [7:0] got[$];
   logic tx_par = 1'b0;

   uart_rx_deframer #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .pc_data    (pc_data),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .parity_err (parity_err),
      .rx_busy    (rx_busy)
   );

   always #(CLK_NS/2) clk = ~clk;

   // Record handshakes and error pulses away from the active edge
   always @(negedge clk) begin
      if (reset) begin
         if (rx_valid && rx_ready) got.push_back(rx_data);
         if (frame_err)  n_ferr++;
         if (overrun)    n_ovr++;
         if (parity_err) n_perr++;
         if (rx_busy)    busy_seen = 1'b1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] got_at(input int i);
      if (i < got.size()) return 32'(got[i]);
      return 32'hDEAD;
   endfunction

   task automatic clear_mon();
      got.delete();
      n_ferr = 0;
      n_ovr  = 0;
      n_perr = 0;
      busy_seen = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int idle_bits);
      @(posedge clk);
      #1;
      pc_data = 1'b0;
      #(BIT_NS);
      for (int i = 0; i < 8; i++) begin
         pc_data = b[i];
         #(BIT_NS);
      end
`ifdef RX_PARITY_EN
      pc_data = tx_par;
      #(BIT_NS);
`endif
      pc_data = stop_bit;
      #(BIT_NS);
      pc_data = 1'b1;
      #(BIT_NS * idle_bits);
   endtask

   logic [7:0] vec [9];

   initial begin
      vec[0] = 8'h03; vec[1] = 8'h00; vec[2] = 8'h20;
      vec[3] = 8'hA0; vec[4] = 8'hC0; vec[5] = 8'hE0;
      vec[6] = 8'h01; vec[7] = 8'h0C; vec[8] = 8'h02;

      // Reset with the line idle
      reset = 1'b1; pc_data = 1'b1; rx_ready = 1'b1;
      #3 reset = 1'b0;
      #3 reset = 1'b1;
      #10000;
      check("rst_valid", 32'(rx_valid), 32'h0);
      check("rst_data", 32'(rx_data), 32'h00);
      check("rst_ferr", 32'(frame_err), 32'h0);
      check("rst_ovr", 32'(overrun), 32'h0);
      check("rst_perr", 32'(parity_err), 32'h0);
      check("rst_busy", 32'(rx_busy), 32'h0);

      // Back-to-back frames with one idle bit
      clear_mon();
      for (int i = 0; i < 9; i++) begin
`ifdef RX_PARITY_EN
         tx_par = ^vec[i];
`endif
         send_frame(vec[i], 1'b1, 1);
      end
      #(BIT_NS);
      check("b2b_count", 32'(got.size()), 32'd9);
      for (int i = 0; i < 9; i++) check($sformatf("b2b_byte%0d", i), got_at(i), 32'(vec[i]));
      check("b2b_ferr", 32'(n_ferr), 32'd0);
      check("b2b_ovr", 32'(n_ovr), 32'd0);
      check("b2b_perr", 32'(n_perr), 32'd0);

      // Short low glitch is rejected at the start-bit centre
      clear_mon();
      @(posedge clk); #1;
      pc_data = 1'b0;
      #100;
      pc_data = 1'b1;
      #(2 * BIT_NS);
      check("glitch_busy_seen", 32'(busy_seen), 32'h1);
      check("glitch_busy_now", 32'(rx_busy), 32'h0);
      check("glitch_valid", 32'(got.size()), 32'd0);
      check("glitch_ferr", 32'(n_ferr), 32'd0);

      // Stop bit low: framing error, byte dropped, next frame fine
      clear_mon();
`ifdef RX_PARITY_EN
      tx_par = 1'b0;
`endif
      send_frame(8'h55, 1'b0, 2);
      check("ferr_pulses", 32'(n_ferr), 32'd1);
      check("ferr_valid", 32'(got.size()), 32'd0);
      check("ferr_rx_valid", 32'(rx_valid), 32'h0);
      send_frame(8'h0C, 1'b1, 2);
      check("ferr_next_count", 32'(got.size()), 32'd1);
      check("ferr_next_byte", got_at(0), 32'h0C);
      check("ferr_next_ferr", 32'(n_ferr), 32'd1);

      // Overrun: second byte dropped while first is unaccepted
      clear_mon();
      rx_ready = 1'b0;
`ifdef RX_PARITY_EN
      tx_par = 1'b1;
`endif
      send_frame(8'h20, 1'b1, 1);
`ifdef RX_PARITY_EN
      tx_par = 1'b0;
`endif
      send_frame(8'hC0, 1'b1, 1);
      check("ovr_valid_held", 32'(rx_valid), 32'h1);
      check("ovr_data_old", 32'(rx_data), 32'h20);
      check("ovr_pulses", 32'(n_ovr), 32'd1);
      @(posedge clk); #1;
      rx_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("ovr_accept_count", 32'(got.size()), 32'd1);
      check("ovr_accept_byte", got_at(0), 32'h20);
      check("ovr_valid_fall", 32'(rx_valid), 32'h0);

      // Reset in the middle of d4 aborts the frame
      clear_mon();
`ifdef RX_PARITY_EN
      tx_par = 1'b1;
`endif
      fork
         send_frame(8'hE0, 1'b1, 1);
         begin
            #(BIT_NS * 5 + BIT_NS / 2 + 10);
            reset = 1'b0;
            #30;
            reset = 1'b1;
         end
      join
      check("midrst_none", 32'(got.size()), 32'd0);
`ifdef RX_PARITY_EN
      tx_par = 1'b1;
`endif
      send_frame(8'h01, 1'b1, 2);
      check("midrst_count", 32'(got.size()), 32'd1);
      check("midrst_byte", got_at(0), 32'h01);
      check("midrst_ferr", 32'(n_ferr), 32'd0);

`ifdef RX_PARITY_EN
      // Even parity: correct bit delivers, wrong bit flags and drops
      clear_mon();
      tx_par = 1'b0;
      send_frame(8'h0C, 1'b1, 2);
      check("par_ok_count", 32'(got.size()), 32'd1);
      check("par_ok_byte", got_at(0), 32'h0C);
      tx_par = 1'b1;
      send_frame(8'h0C, 1'b1, 2);
      check("par_bad_pulses", 32'(n_perr), 32'd1);
      check("par_bad_count", 32'(got.size()), 32'd1);
      check("par_bad_ferr", 32'(n_ferr), 32'd0);
`else
      check("par_tied_low", 32'(n_perr), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
